uart_sram_loader: RTL

Controller that sequences the UART receive path into the board SRAM. It parses a framed byte stream from the receiver (sync byte, 16-bit word count, payload, optional checksum) and packs payload bytes little-endian into 32-bit words. It issues one request/acknowledge SRAM write per word at consecutive addresses, and reports completion or error. It sits between the baud-clocked receiver (after its pulse is synchronised into `clk`) and the SRAM port arbiter.

---
 rtl/uart_sram_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_sram_loader.sv
// rtl/uart_sram_loader.sv - UART frame parser that packs payload into 32-bit SRAM writes (optional checksum: UART_LOADER_CHECKSUM_EN)
module uart_sram_loader #(
  parameter int unsigned       ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       TIMEOUT_CYC = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_ferr,
  output logic              sram_req,
  input  logic              sram_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef UART_LOADER_CHECKSUM_EN
    CHK,
`endif
    FINISH,
    ERR
  } state_t;

  state_t      state, next_state;
  logic [7:0]  len_hi;
  logic [15:0] words_left;
  logic [1:0]  byte_idx;
  logic [23:0] pack_reg;
  logic [31:0] idle_cnt;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  xor_acc;
`endif

  logic       start, len_hi_take, len_lo_take, byte_take, word_load;
  logic       done_set, err_set, ack_fire, timed, timeout;
  logic [1:0] err_val;

  assign ack_fire = sram_req & sram_ack;
  assign busy     = (state != IDLE);
  assign timeout  = timed && (idle_cnt >= TIMEOUT_CYC);

  // Inter-byte timeout only applies while the frame is still expecting bytes
  always_comb begin
    timed = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA: timed = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
      CHK:                  timed = 1'b1;
`endif
      default:              timed = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and control strobes; errors take priority over byte handling
  always_comb begin
    next_state  = state;
    start       = 1'b0;
    len_hi_take = 1'b0;
    len_lo_take = 1'b0;
    byte_take   = 1'b0;
    word_load   = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    err_val     = 2'd0;
    if (state != IDLE && state != ERR && rx_ferr) begin
      err_set = 1'b1;
      err_val = 2'd1;
    end else if (timeout) begin
      err_set = 1'b1;
      err_val = 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && !rx_ferr && rx_data == 8'hA5) begin
            start      = 1'b1;
            next_state = LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            len_hi_take = 1'b1;
            next_state  = LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_valid) begin
            len_lo_take = 1'b1;
            if ({len_hi, rx_data} == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              next_state = CHK;
`else
              next_state = IDLE;
              done_set   = 1'b1;
`endif
            end else begin
              next_state = DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            byte_take = 1'b1;
            if (byte_idx == 2'd3) begin
              // A word finishing while the previous write is still unaccepted has nowhere to go
              if (sram_req && !sram_ack) begin
                err_set = 1'b1;
                err_val = 2'd3;
              end else begin
                word_load = 1'b1;
                if (words_left == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                  next_state = CHK;
`else
                  next_state = FINISH;
`endif
                end
              end
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        CHK: begin
          if (rx_valid) begin
            if (rx_data != xor_acc) begin
              err_set = 1'b1;
              err_val = 2'd3;
            end else if (!sram_req || ack_fire) begin
              next_state = IDLE;
              done_set   = 1'b1;
            end else begin
              next_state = FINISH;
            end
          end
        end
`endif
        FINISH: begin
          if (!sram_req || ack_fire) begin
            next_state = IDLE;
            done_set   = 1'b1;
          end
        end
        ERR: begin
          if (!sram_req || ack_fire) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
    if (err_set) next_state = ERR;
  end

  // Datapath: length capture, byte packing, write handshake, error flags, timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_req   <= 1'b0;
      sram_addr  <= BASE_ADDR;
      sram_wdata <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      len_hi     <= 8'd0;
      words_left <= 16'd0;
      byte_idx   <= 2'd0;
      pack_reg   <= 24'd0;
      idle_cnt   <= 32'd0;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_acc    <= 8'd0;
`endif
    end else begin
      done <= done_set;
      if (start) begin
        err       <= 1'b0;
        err_code  <= 2'd0;
        sram_addr <= BASE_ADDR;
        byte_idx  <= 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
        xor_acc   <= 8'd0;
`endif
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_val;
      end
      if (len_hi_take) len_hi <= rx_data;
      if (len_lo_take) begin
        words_left <= {len_hi, rx_data};
        byte_idx   <= 2'd0;
      end
      if (byte_take) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    pack_reg[7:0]   <= rx_data;
          2'd1:    pack_reg[15:8]  <= rx_data;
          2'd2:    pack_reg[23:16] <= rx_data;
          default: pack_reg        <= pack_reg;
        endcase
`ifdef UART_LOADER_CHECKSUM_EN
        xor_acc <= xor_acc ^ rx_data;
`endif
      end
      // Address advances on every accepted write; a word loaded in the same cycle takes the new slot
      if (ack_fire) begin
        sram_req  <= 1'b0;
        sram_addr <= sram_addr + ADDR_W'(1);
      end
      if (word_load) begin
        sram_req   <= 1'b1;
        sram_wdata <= {rx_data, pack_reg};
        words_left <= words_left - 16'd1;
      end
      if (rx_valid || !timed) idle_cnt <= 32'd0;
      else if (!timeout)      idle_cnt <= idle_cnt + 32'd1;
    end
  end

endmodule
